// File: rtl/cam_pkg.sv
// Shared types and constants for the OV5640 DVP capture path.
// Holds the capture FSM states, RGB565 field positions and the RGB565->RGB888 expansion.
package cam_pkg;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_SKIP = 2'd1,
        S_RUN  = 2'd2
    } cam_state_t;

    localparam int CNT_W = 12;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // Widen each channel by replicating its MSBs into the new low bits, so full scale stays full scale.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = p[R_MSB:R_LSB];
        g6 = p[G_MSB:G_LSB];
        b5 = p[B_MSB:B_LSB];
        return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// Pairs DVP bytes into RGB565 pixels (high byte first) and expands them to RGB888.
// Flags a leftover byte when a line ends on an odd byte count.
module cam_byte_packer
    import cam_pkg::*;
(
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        line_active,
    input  logic [7:0]  byte_in,
    output logic        pix_stb,
    output logic [15:0] pix_data,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        odd_drop
);

    logic       phase;
    logic [7:0] hi_byte;
    logic [23:0] rgb888;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            phase   <= 1'b0;
            hi_byte <= 8'd0;
        end else if (!line_active) begin
            phase <= 1'b0;
        end else begin
            if (!phase) begin
                hi_byte <= byte_in;
            end
            phase <= ~phase;
        end
    end

    // A phase still set on the first idle cycle means the line ended with an unpaired high byte.
    assign pix_stb  = line_active & phase;
    assign pix_data = {hi_byte, byte_in};
    assign odd_drop = ~line_active & phase;

    assign rgb888 = rgb565_to_888(pix_data);
    assign pix_r  = rgb888[23:16];
    assign pix_g  = rgb888[15:8];
    assign pix_b  = rgb888[7:0];

endmodule

// File: rtl/ov5640_dvp_capture.sv
// OV5640 DVP capture: input registering, settle-frame skipping, pixel/line/frame markers
// and per-frame geometry status for the downstream frame buffer.
module ov5640_dvp_capture
    import cam_pkg::*;
#(
    parameter int H_RES       = 1280,
    parameter int V_RES       = 720,
    parameter int SKIP_FRAMES = 10,
    parameter int VS_POL      = 1
)
(
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_vsync,
    input  logic              I_href,
    input  logic [7:0]        I_data,
    input  logic              I_capture_en,
    input  logic              I_err_clr,
    output logic              O_pix_valid,
    output logic [15:0]       O_pix_data,
    output logic [7:0]        O_r,
    output logic [7:0]        O_g,
    output logic [7:0]        O_b,
    output logic              O_sof,
    output logic              O_eol,
    output logic              O_frame_done,
    output logic              O_frame_err,
    output logic              O_err_sticky,
    output logic [CNT_W-1:0]  O_last_width,
    output logic [CNT_W-1:0]  O_last_height,
    output logic [7:0]        O_frame_cnt
);

    localparam logic             VS_LVL  = (VS_POL != 0);
    localparam logic [CNT_W-1:0] H_EXP   = CNT_W'(H_RES);
    localparam logic [CNT_W-1:0] V_EXP   = CNT_W'(V_RES);
    localparam logic [15:0]      SKIP_LAST = 16'(SKIP_FRAMES - 1);

    logic             vs_q;
    logic             hr_q;
    logic [7:0]       d_q;
    logic             vs_act_d;
    logic             hr_en_d;
    logic             vs_act;
    logic             hr_en;
    logic             boundary;
    logic             hr_fall;

    cam_state_t       state;
    cam_state_t       state_nx;
    logic [15:0]      skip_cnt;
    logic             in_run;
    logic             skip_clr;
    logic             skip_inc;

    logic             frame_active;
    logic             capturing;
    logic             frame_end;
    logic             frame_err_nx;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic [CNT_W-1:0] line_w;
    logic             line_err;

    logic             pix_stb;
    logic [15:0]      pix_data;
    logic [7:0]       pix_r;
    logic [7:0]       pix_g;
    logic [7:0]       pix_b;
    logic             odd_drop;

    // vs_q resets to the inactive level so the first cycle after reset never looks like a boundary.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vs_q     <= ~VS_LVL;
            hr_q     <= 1'b0;
            d_q      <= 8'd0;
            vs_act_d <= 1'b0;
            hr_en_d  <= 1'b0;
        end else begin
            vs_q     <= I_vsync;
            hr_q     <= I_href;
            d_q      <= I_data;
            vs_act_d <= vs_act;
            hr_en_d  <= hr_en;
        end
    end

    assign vs_act   = (vs_q == VS_LVL);
    assign hr_en    = hr_q & ~vs_act;
    assign boundary = vs_act & ~vs_act_d;
    assign hr_fall  = hr_en_d & ~hr_en;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state <= S_SYNC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_SYNC: if (boundary) state_nx = (SKIP_FRAMES == 0) ? S_RUN : S_SKIP;
            S_SKIP: if (boundary && skip_cnt == SKIP_LAST) state_nx = S_RUN;
            S_RUN:  state_nx = S_RUN;
            default: state_nx = S_SYNC;
        endcase
    end

    always_comb begin
        in_run   = (state == S_RUN);
        skip_clr = (state == S_SYNC);
        skip_inc = (state == S_SKIP) & boundary;
    end

    // frame_active only changes on boundaries seen from S_RUN, so the frame that
    // begins on the entry boundary is still discarded.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            skip_cnt     <= 16'd0;
            frame_active <= 1'b0;
        end else begin
            if (skip_clr) begin
                skip_cnt <= 16'd0;
            end else if (skip_inc) begin
                skip_cnt <= skip_cnt + 16'd1;
            end
            if (in_run && boundary) begin
                frame_active <= I_capture_en;
            end
        end
    end

    assign capturing    = in_run & frame_active;
    assign frame_end    = boundary & capturing & (line_cnt != '0);
    assign frame_err_nx = line_err | (line_cnt != V_EXP);

    cam_byte_packer u_packer (
        .I_clk       (I_clk),
        .I_rst_n     (I_rst_n),
        .line_active (hr_en),
        .byte_in     (d_q),
        .pix_stb     (pix_stb),
        .pix_data    (pix_data),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .odd_drop    (odd_drop)
    );

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            line_w   <= '0;
            line_err <= 1'b0;
        end else if (boundary) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            line_w   <= '0;
            line_err <= 1'b0;
        end else if (capturing) begin
            if (pix_stb && pix_cnt != '1) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
            if (hr_fall) begin
                pix_cnt <= '0;
                line_w  <= pix_cnt;
                if (line_cnt != '1) begin
                    line_cnt <= line_cnt + 1'b1;
                end
                if (pix_cnt != H_EXP || odd_drop) begin
                    line_err <= 1'b1;
                end
            end
        end
    end

    // A new frame error takes priority over a simultaneous clear of the sticky flag.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_pix_valid   <= 1'b0;
            O_pix_data    <= 16'd0;
            O_r           <= 8'd0;
            O_g           <= 8'd0;
            O_b           <= 8'd0;
            O_sof         <= 1'b0;
            O_eol         <= 1'b0;
            O_frame_done  <= 1'b0;
            O_frame_err   <= 1'b0;
            O_err_sticky  <= 1'b0;
            O_last_width  <= '0;
            O_last_height <= '0;
            O_frame_cnt   <= 8'd0;
        end else begin
            O_pix_valid  <= capturing & pix_stb;
            O_sof        <= capturing & pix_stb & (pix_cnt == '0) & (line_cnt == '0);
            O_eol        <= capturing & hr_fall & (pix_cnt != '0);
            O_frame_done <= frame_end;
            if (capturing && pix_stb) begin
                O_pix_data <= pix_data;
                O_r        <= pix_r;
                O_g        <= pix_g;
                O_b        <= pix_b;
            end
            if (frame_end) begin
                O_last_width  <= line_w;
                O_last_height <= line_cnt;
                O_frame_err   <= frame_err_nx;
                O_frame_cnt   <= O_frame_cnt + 8'd1;
            end
            if (frame_end && frame_err_nx) begin
                O_err_sticky <= 1'b1;
            end else if (I_err_clr) begin
                O_err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ov5640_dvp_capture.md
Name: ov5640_dvp_capture

Overview:
Camera-side capture stage for the OV5640 path. Registers the 8-bit DVP bus, pairs bytes into RGB565 pixels and expands them to RGB888. Generates frame/line markers and per-frame geometry status for the downstream frame buffer that feeds the HDMI pixel domain. Discards the frames the sensor emits while it settles after configuration.

Parameters:
H_RES, 1280, expected pixels per line
V_RES, 720, expected lines per frame
SKIP_FRAMES, 10, whole frames discarded after first sync (0 allowed)
VS_POL, 1, vsync active level (1 = active-high)

Ports:
I_clk  in  1  camera pixel clock (cmos_pclk)
I_rst_n  in  1  reset
I_vsync  in  1  DVP vsync
I_href  in  1  DVP href, byte valid
I_data  in  8  DVP byte
I_capture_en  in  1  capture enable, sampled at frame boundaries only
I_err_clr  in  1  clears O_err_sticky
O_pix_valid  out  1  pixel strobe
O_pix_data  out  16  RGB565 {R5,G6,B5}
O_r / O_g / O_b  out  8 each  RGB888, MSB-replicated
O_sof  out  1  high with first pixel of captured frame
O_eol  out  1  1-cycle pulse, end of captured line
O_frame_done  out  1  1-cycle pulse, end of captured frame
O_frame_err  out  1  geometry error of last frame, valid with O_frame_done
O_err_sticky  out  1  set by any frame error
O_last_width  out  12  pixel count of last line of last frame
O_last_height  out  12  line count of last frame
O_frame_cnt  out  8  captured frames, wraps 255->0

Behaviour:
- Reset is I_rst_n, asynchronous, active-low; clock is I_clk. Every output resets to 0, state resets to S_SYNC, all counters reset to 0.
- Input stage: I_vsync, I_href, I_data registered once (vs_q, hr_q, d_q). Boundary = vs_q reaching VS_POL from inactive (edge detect on vs_q).
- FSM:
  - S_SYNC: wait for boundary. Go to S_SKIP with skip_cnt=0, or to S_RUN if SKIP_FRAMES=0.
  - S_SKIP: each boundary increments skip_cnt. At skip_cnt=SKIP_FRAMES-1, the next boundary moves to S_RUN.
  - S_RUN: at each boundary, frame_active <= I_capture_en.
- No pixel, O_sof, O_eol or O_frame_done output outside S_RUN.
- Byte pairing: while hr_q=1 and vs_q inactive, phase toggles per byte. Phase 0 holds the high byte; phase 1 completes the pixel {hi,lo}. Phase clears whenever hr_q=0.
- Latency: O_pix_valid is registered and asserts the cycle after the register edge that captured the low byte, i.e. 2 cycles after I_data carries it.
- Expansion: r={R5,R5[4:2]}, g={G6,G6[5:4]}, b={B5,B5[4:2]}.
- Counting:
  - pix_cnt counts pixels per line; line_cnt increments at hr_q falling edge. Both are 12-bit and saturate at 4095.
  - O_eol pulses on the cycle after hr_q falls, only if the line produced at least 1 pixel.
  - An odd byte count drops the leftover byte and sets the line error.
- Line/frame error: set if pix_cnt != H_RES or a byte was dropped.
- Frame end: a boundary while frame_active and line_cnt>0 does all of the following in one cycle:
  - latch O_last_width/O_last_height;
  - set O_frame_err = (line_err | line_cnt != V_RES);
  - pulse O_frame_done; increment O_frame_cnt;
  - set O_err_sticky if the frame errored, then clear the counters.
- The same boundary starts the next frame; its O_sof comes with that frame's first pixel.
- O_err_sticky: if I_err_clr and a new error occur in the same cycle, set wins.
- href while vsync is active is ignored.
- Reset mid-frame restarts in S_SYNC, so the partial frame is discarded and skipping restarts.

Decomposition:
- Shared package cam_pkg: state enum (S_SYNC, S_SKIP, S_RUN), RGB565 field bit positions, counter width constant CNT_W=12.
- Sub-module cam_byte_packer: phase, hi-byte register, pixel assembly, odd-byte flag, RGB888 expansion. Top level keeps the FSM, counters and status.

Test Plan:
- SKIP_FRAMES=1, H_RES=4, V_RES=2; drive 3 vsync pulses, each followed by 2 lines of 8 bytes -> no O_pix_valid for frames 1-2, 8 pixels from frame 3. Fourth vsync -> O_frame_done=1, O_last_width=4, O_last_height=2, O_frame_err=0, O_frame_cnt=1.
- In S_RUN, bytes 0xF8,0x1F -> O_pix_data=0xF81F, O_r=0xFF, O_g=0x00, O_b=0xFF. Valid exactly 2 cycles after 0x1F is on I_data.
- Line of 7 bytes -> 3 pixels, O_eol pulse; at frame end O_frame_err=1 and O_err_sticky=1. Pulse I_err_clr -> O_err_sticky=0.
- Frame with 3 lines of 4 pixels (V_RES=2) -> O_last_height=3, O_frame_err=1.
- I_capture_en=0 at a boundary -> that frame produces no pixels and no O_frame_done, and O_frame_cnt is unchanged.
- Assert I_rst_n=0 mid-line -> all outputs 0 immediately. After release, the next pixels appear only after re-sync plus SKIP_FRAMES frames.
